// File: rtl/vai_rx_demux.sv
`default_nettype none
// ============================================================================
// Module   : vai_rx_demux
// Brief    : Two-stage demultiplexer that steers upstream c0/c1 responses and
//            MMIO requests to sub-AFU ports by the 4-bit tag field.
// Revision : 1.0 - initial release
// ============================================================================
module vai_rx_demux #(
    parameter int NUM_SUB_AFUS = 9,
    parameter int TAG_LSB      = 12
) (
    input  logic                         pClk,
    input  logic                         SoftReset,

    input  logic                         up_c0_valid,
    input  logic [15:0]                  up_c0_mdata,
    input  logic [511:0]                 up_c0_data,
    input  logic                         up_c1_valid,
    input  logic [15:0]                  up_c1_mdata,
    input  logic                         up_mmio_valid,
    input  logic [15:0]                  up_mmio_addr,
    input  logic [63:0]                  up_mmio_wdata,
    input  logic                         up_mmio_rd,

    input  logic [NUM_SUB_AFUS-1:0]      afu_quiesce,

    output logic [NUM_SUB_AFUS-1:0]      afu_c0_valid,
    output logic [NUM_SUB_AFUS-1:0]      afu_c1_valid,
    output logic [NUM_SUB_AFUS-1:0]      afu_mmio_valid,
    output logic [15:0]                  afu_c0_mdata,
    output logic [511:0]                 afu_c0_data,
    output logic [15:0]                  afu_c1_mdata,
    output logic [15:0]                  afu_mmio_addr,
    output logic [63:0]                  afu_mmio_wdata,
    output logic                         afu_mmio_rd,

    output logic [15:0]                  drop_cnt,
    output logic [NUM_SUB_AFUS*16-1:0]   resp_cnt
);

    localparam logic [15:0] c_TAG_MASK = 16'hF << TAG_LSB;
    localparam logic [15:0] c_DROP_MAX = 16'hFFFF;

    // ------------------------------------------------------------------
    // Stage 1: capture upstream events
    // ------------------------------------------------------------------
    logic         r_s1_c0_valid;
    logic         r_s1_c1_valid;
    logic         r_s1_mmio_valid;
    logic [15:0]  r_s1_c0_mdata;
    logic [511:0] r_s1_c0_data;
    logic [15:0]  r_s1_c1_mdata;
    logic [15:0]  r_s1_mmio_addr;
    logic [63:0]  r_s1_mmio_wdata;
    logic         r_s1_mmio_rd;

    always_ff @(posedge pClk or posedge SoftReset) begin
        if (SoftReset) begin
            r_s1_c0_valid   <= 1'b0;
            r_s1_c1_valid   <= 1'b0;
            r_s1_mmio_valid <= 1'b0;
        end else begin
            r_s1_c0_valid   <= up_c0_valid;
            r_s1_c1_valid   <= up_c1_valid;
            r_s1_mmio_valid <= up_mmio_valid;
        end
    end

    // Payload only loads with a valid so idle cycles keep the last event.
    always_ff @(posedge pClk) begin
        if (up_c0_valid) begin
            r_s1_c0_mdata <= up_c0_mdata;
            r_s1_c0_data  <= up_c0_data;
        end
        if (up_c1_valid) begin
            r_s1_c1_mdata <= up_c1_mdata;
        end
        if (up_mmio_valid) begin
            r_s1_mmio_addr  <= up_mmio_addr;
            r_s1_mmio_wdata <= up_mmio_wdata;
            r_s1_mmio_rd    <= up_mmio_rd;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 decode: one-hot select per channel, quiesce applied here
    // ------------------------------------------------------------------
    logic [3:0]              w_c0_idx;
    logic [3:0]              w_c1_idx;
    logic [3:0]              w_mmio_idx;
    logic [NUM_SUB_AFUS-1:0] w_c0_sel;
    logic [NUM_SUB_AFUS-1:0] w_c1_sel;
    logic [NUM_SUB_AFUS-1:0] w_mmio_sel;
    logic                    w_c0_drop;
    logic                    w_c1_drop;
    logic                    w_mmio_drop;

    assign w_c0_idx   = r_s1_c0_mdata[TAG_LSB+3:TAG_LSB];
    assign w_c1_idx   = r_s1_c1_mdata[TAG_LSB+3:TAG_LSB];
    assign w_mmio_idx = r_s1_mmio_addr[TAG_LSB+3:TAG_LSB];

    // Indices beyond NUM_SUB_AFUS match no select bit and fall into drop.
    generate
        for (genvar i = 0; i < NUM_SUB_AFUS; i++) begin : g_route
            assign w_c0_sel[i]   = r_s1_c0_valid   && (32'(w_c0_idx)   == i) && !afu_quiesce[i];
            assign w_c1_sel[i]   = r_s1_c1_valid   && (32'(w_c1_idx)   == i) && !afu_quiesce[i];
            assign w_mmio_sel[i] = r_s1_mmio_valid && (32'(w_mmio_idx) == i) && !afu_quiesce[i];
        end
    endgenerate

    assign w_c0_drop   = r_s1_c0_valid   && !(|w_c0_sel);
    assign w_c1_drop   = r_s1_c1_valid   && !(|w_c1_sel);
    assign w_mmio_drop = r_s1_mmio_valid && !(|w_mmio_sel);

    // ------------------------------------------------------------------
    // Stage 2 registers: valids, payload, drop counter
    // ------------------------------------------------------------------
    logic [NUM_SUB_AFUS-1:0] r_c0_valid;
    logic [NUM_SUB_AFUS-1:0] r_c1_valid;
    logic [NUM_SUB_AFUS-1:0] r_mmio_valid;
    logic [15:0]             r_c0_mdata;
    logic [511:0]            r_c0_data;
    logic [15:0]             r_c1_mdata;
    logic [15:0]             r_mmio_addr;
    logic [63:0]             r_mmio_wdata;
    logic                    r_mmio_rd;
    logic [15:0]             r_drop_cnt;

    logic [1:0]              w_drop_inc;
    logic [16:0]             w_drop_sum;
    logic [15:0]             w_drop_next;

    assign w_drop_inc  = 2'(w_c0_drop) + 2'(w_c1_drop) + 2'(w_mmio_drop);
    assign w_drop_sum  = {1'b0, r_drop_cnt} + {15'b0, w_drop_inc};
    assign w_drop_next = w_drop_sum[16] ? c_DROP_MAX : w_drop_sum[15:0];

    always_ff @(posedge pClk or posedge SoftReset) begin
        if (SoftReset) begin
            r_c0_valid   <= '0;
            r_c1_valid   <= '0;
            r_mmio_valid <= '0;
            r_drop_cnt   <= '0;
        end else begin
            r_c0_valid   <= w_c0_sel;
            r_c1_valid   <= w_c1_sel;
            r_mmio_valid <= w_mmio_sel;
            r_drop_cnt   <= w_drop_next;
        end
    end

    always_ff @(posedge pClk) begin
        if (r_s1_c0_valid) begin
            r_c0_mdata <= r_s1_c0_mdata & ~c_TAG_MASK;
            r_c0_data  <= r_s1_c0_data;
        end
        if (r_s1_c1_valid) begin
            r_c1_mdata <= r_s1_c1_mdata & ~c_TAG_MASK;
        end
        if (r_s1_mmio_valid) begin
            r_mmio_addr  <= r_s1_mmio_addr & ~c_TAG_MASK;
            r_mmio_wdata <= r_s1_mmio_wdata;
            r_mmio_rd    <= r_s1_mmio_rd;
        end
    end

    // ------------------------------------------------------------------
    // Per-AFU delivered response counters (c0 + c1), wrapping
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_SUB_AFUS; i++) begin : g_resp
            logic [15:0] r_resp_cnt;
            logic [1:0]  w_resp_inc;

            assign w_resp_inc = 2'(w_c0_sel[i]) + 2'(w_c1_sel[i]);

            always_ff @(posedge pClk or posedge SoftReset) begin
                if (SoftReset) begin
                    r_resp_cnt <= '0;
                end else begin
                    r_resp_cnt <= r_resp_cnt + {14'b0, w_resp_inc};
                end
            end

            assign resp_cnt[i*16 +: 16] = r_resp_cnt;
        end
    endgenerate

    assign afu_c0_valid   = r_c0_valid;
    assign afu_c1_valid   = r_c1_valid;
    assign afu_mmio_valid = r_mmio_valid;
    assign afu_c0_mdata   = r_c0_mdata;
    assign afu_c0_data    = r_c0_data;
    assign afu_c1_mdata   = r_c1_mdata;
    assign afu_mmio_addr  = r_mmio_addr;
    assign afu_mmio_wdata = r_mmio_wdata;
    assign afu_mmio_rd    = r_mmio_rd;
    assign drop_cnt       = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vai_rx_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_vai_rx_demux
// Brief    : Randomised scoreboard bench for vai_rx_demux with a queue-based
//            reference model and a decoupled output monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vai_rx_demux;

    localparam int N       = 9;
    localparam int TAG_LSB = 12;

    logic           pClk = 1'b0;
    logic           SoftReset;
    logic           up_c0_valid, up_c1_valid, up_mmio_valid, up_mmio_rd;
    logic [15:0]    up_c0_mdata, up_c1_mdata, up_mmio_addr;
    logic [511:0]   up_c0_data;
    logic [63:0]    up_mmio_wdata;
    logic [N-1:0]   afu_quiesce;
    logic [N-1:0]   afu_c0_valid, afu_c1_valid, afu_mmio_valid;
    logic [15:0]    afu_c0_mdata, afu_c1_mdata, afu_mmio_addr, drop_cnt;
    logic [511:0]   afu_c0_data;
    logic [63:0]    afu_mmio_wdata;
    logic           afu_mmio_rd;
    logic [N*16-1:0] resp_cnt;

    vai_rx_demux #(.NUM_SUB_AFUS(N), .TAG_LSB(TAG_LSB)) dut (
        .pClk(pClk), .SoftReset(SoftReset),
        .up_c0_valid(up_c0_valid), .up_c0_mdata(up_c0_mdata), .up_c0_data(up_c0_data),
        .up_c1_valid(up_c1_valid), .up_c1_mdata(up_c1_mdata),
        .up_mmio_valid(up_mmio_valid), .up_mmio_addr(up_mmio_addr),
        .up_mmio_wdata(up_mmio_wdata), .up_mmio_rd(up_mmio_rd),
        .afu_quiesce(afu_quiesce),
        .afu_c0_valid(afu_c0_valid), .afu_c1_valid(afu_c1_valid), .afu_mmio_valid(afu_mmio_valid),
        .afu_c0_mdata(afu_c0_mdata), .afu_c0_data(afu_c0_data), .afu_c1_mdata(afu_c1_mdata),
        .afu_mmio_addr(afu_mmio_addr), .afu_mmio_wdata(afu_mmio_wdata), .afu_mmio_rd(afu_mmio_rd),
        .drop_cnt(drop_cnt), .resp_cnt(resp_cnt)
    );

    always #5 pClk = ~pClk;

    int cyc = 0;
    always @(posedge pClk) cyc <= cyc + 1;

    typedef struct {
        int           stamp;
        logic [N-1:0] vec;
        logic [15:0]  tag;
        logic [511:0] data;
        logic [63:0]  wdata;
        logic         rd;
    } ev_t;

    typedef struct {
        int              stamp;
        logic [15:0]     drop;
        logic [N*16-1:0] resp;
    } snap_t;

    ev_t   q0[$], q1[$], qm[$];
    snap_t qs[$];

    int nTests = 0;
    int nFail  = 0;

    // Reference model state: counters and the event waiting for its quiesce sample
    int           m_drop;
    logic [15:0]  m_resp [N];
    bit           p_c0v, p_c1v, p_mv, p_mrd;
    logic [15:0]  p_c0m, p_c1m, p_ma;
    logic [511:0] p_c0d;
    logic [63:0]  p_mw;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Destination AFU for a tag under the quiesce mask, or -1 when dropped.
    function automatic int dest(input logic [15:0] tag, input logic [N-1:0] q);
        int idx;
        idx = (int'(tag) >> TAG_LSB) % 16;
        if (idx < N && q[idx] == 1'b0) return idx;
        return -1;
    endfunction

    function automatic void count_drop();
        if (m_drop < 65535) m_drop++;
    endfunction

    function automatic ev_t mk(input int stamp, input int idx, input logic [15:0] tag,
                               input logic [511:0] d, input logic [63:0] w, input logic rd);
        ev_t e;
        e.stamp = stamp;
        e.vec   = '0;
        e.vec[idx] = 1'b1;
        e.tag   = tag - 16'(idx << TAG_LSB);
        e.data  = d;
        e.wdata = w;
        e.rd    = rd;
        return e;
    endfunction

    // Drives one cycle of stimulus; the previous cycle's event is resolved
    // with the quiesce value presented alongside this one.
    task automatic step(input bit c0v, input logic [15:0] c0m, input logic [511:0] c0d,
                        input bit c1v, input logic [15:0] c1m,
                        input bit mv, input logic [15:0] ma, input logic [63:0] mw, input bit mrd,
                        input logic [N-1:0] q);
        int m, d;
        snap_t s;
        @(negedge pClk);
        up_c0_valid = c0v; up_c0_mdata = c0m; up_c0_data = c0d;
        up_c1_valid = c1v; up_c1_mdata = c1m;
        up_mmio_valid = mv; up_mmio_addr = ma; up_mmio_wdata = mw; up_mmio_rd = mrd;
        afu_quiesce = q;
        m = cyc + 1;
        if (p_c0v) begin
            d = dest(p_c0m, q);
            if (d >= 0) begin q0.push_back(mk(m, d, p_c0m, p_c0d, '0, 1'b0)); m_resp[d]++; end
            else count_drop();
        end
        if (p_c1v) begin
            d = dest(p_c1m, q);
            if (d >= 0) begin q1.push_back(mk(m, d, p_c1m, '0, '0, 1'b0)); m_resp[d]++; end
            else count_drop();
        end
        if (p_mv) begin
            d = dest(p_ma, q);
            if (d >= 0) qm.push_back(mk(m, d, p_ma, '0, p_mw, p_mrd));
            else count_drop();
        end
        p_c0v = c0v; p_c0m = c0m; p_c0d = c0d;
        p_c1v = c1v; p_c1m = c1m;
        p_mv = mv; p_ma = ma; p_mw = mw; p_mrd = mrd;
        s.stamp = m;
        s.drop  = 16'(m_drop);
        for (int i = 0; i < N; i++) s.resp[i*16 +: 16] = m_resp[i];
        qs.push_back(s);
    endtask

    task automatic idle(input int n, input logic [N-1:0] q);
        for (int i = 0; i < n; i++) step(0, 16'h0, '0, 0, 16'h0, 0, 16'h0, 64'h0, 0, q);
    endtask

    task automatic do_reset(input int hold);
        @(negedge pClk);
        SoftReset = 1'b1;
        up_c0_valid = 0; up_c1_valid = 0; up_mmio_valid = 0; afu_quiesce = '0;
        p_c0v = 0; p_c1v = 0; p_mv = 0;
        m_drop = 0;
        for (int i = 0; i < N; i++) m_resp[i] = 16'h0;
        q0.delete(); q1.delete(); qm.delete(); qs.delete();
        repeat (hold) @(negedge pClk);
        SoftReset = 1'b0;
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Monitor: compares DUT outputs against the scoreboard every cycle
    initial begin
        ev_t e;
        snap_t s;
        forever begin
            @(posedge pClk);
            #1;
            if (SoftReset) begin
                chk("rst_c0_valid", 512'(afu_c0_valid), 512'h0);
                chk("rst_c1_valid", 512'(afu_c1_valid), 512'h0);
                chk("rst_mmio_valid", 512'(afu_mmio_valid), 512'h0);
                chk("rst_drop_cnt", 512'(drop_cnt), 512'h0);
                chk("rst_resp_cnt", 512'(resp_cnt), 512'h0);
            end else begin
                while (q0.size() > 0 && q0[0].stamp < cyc) begin e = q0.pop_front(); chk("c0_missing", 512'(afu_c0_valid), 512'(e.vec)); end
                if (q0.size() > 0 && q0[0].stamp == cyc) begin
                    e = q0.pop_front();
                    chk("c0_valid", 512'(afu_c0_valid), 512'(e.vec));
                    chk("c0_mdata", 512'(afu_c0_mdata), 512'(e.tag));
                    chk("c0_data", afu_c0_data, e.data);
                end else chk("c0_spurious", 512'(afu_c0_valid), 512'h0);

                while (q1.size() > 0 && q1[0].stamp < cyc) begin e = q1.pop_front(); chk("c1_missing", 512'(afu_c1_valid), 512'(e.vec)); end
                if (q1.size() > 0 && q1[0].stamp == cyc) begin
                    e = q1.pop_front();
                    chk("c1_valid", 512'(afu_c1_valid), 512'(e.vec));
                    chk("c1_mdata", 512'(afu_c1_mdata), 512'(e.tag));
                end else chk("c1_spurious", 512'(afu_c1_valid), 512'h0);

                while (qm.size() > 0 && qm[0].stamp < cyc) begin e = qm.pop_front(); chk("mmio_missing", 512'(afu_mmio_valid), 512'(e.vec)); end
                if (qm.size() > 0 && qm[0].stamp == cyc) begin
                    e = qm.pop_front();
                    chk("mmio_valid", 512'(afu_mmio_valid), 512'(e.vec));
                    chk("mmio_addr", 512'(afu_mmio_addr), 512'(e.tag));
                    chk("mmio_wdata", 512'(afu_mmio_wdata), 512'(e.wdata));
                    chk("mmio_rd", 512'(afu_mmio_rd), 512'(e.rd));
                end else chk("mmio_spurious", 512'(afu_mmio_valid), 512'h0);

                while (qs.size() > 0 && qs[0].stamp < cyc) void'(qs.pop_front());
                if (qs.size() > 0 && qs[0].stamp == cyc) begin
                    s = qs.pop_front();
                    chk("drop_cnt", 512'(drop_cnt), 512'(s.drop));
                    chk("resp_cnt", 512'(resp_cnt), 512'(s.resp));
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [N-1:0] q;
        logic [15:0]  t0, t1, ta;
        SoftReset = 1'b1;
        up_c0_valid = 0; up_c1_valid = 0; up_mmio_valid = 0; up_mmio_rd = 0;
        up_c0_mdata = 0; up_c1_mdata = 0; up_mmio_addr = 0; up_mmio_wdata = 0;
        up_c0_data = '0; afu_quiesce = '0;
        do_reset(3);

        // Single c0 response to AFU 3
        step(1, 16'h3005, {16{32'hA5A5A5A5}}, 0, 16'h0, 0, 16'h0, 64'h0, 0, '0);
        idle(2, '0);
        // MMIO read to AFU 8, then to out-of-range AFU 9
        step(0, 16'h0, '0, 0, 16'h0, 1, 16'h8010, 64'h1122334455667788, 1, '0);
        step(0, 16'h0, '0, 0, 16'h0, 1, 16'h9010, 64'h0, 1, '0);
        idle(2, '0);
        // Same-cycle c0 and c1 to AFU 1, plus an MMIO write to AFU 0
        step(1, 16'h1001, rnd512(), 1, 16'h1002, 1, 16'h0ABC, 64'hDEADBEEF, 0, '0);
        idle(2, '0);
        // Quiesced AFU 2 drops, then the same event after release delivers
        step(0, 16'h0, '0, 1, 16'h2000, 0, 16'h0, 64'h0, 0, N'(9'h004));
        idle(2, N'(9'h004));
        step(0, 16'h0, '0, 1, 16'h2000, 0, 16'h0, 64'h0, 0, '0);
        idle(2, '0);
        // Quiesce raised only in the cycle after input still drops the event
        step(1, 16'h2123, rnd512(), 0, 16'h0, 0, 16'h0, 64'h0, 0, '0);
        idle(1, N'(9'h004));
        idle(1, '0);
        // Quiesce released in the cycle after input lets the event through
        step(1, 16'h2124, rnd512(), 0, 16'h0, 0, 16'h0, 64'h0, 0, N'(9'h004));
        idle(2, '0);

        // Randomised traffic with sporadic quiesce
        for (int i = 0; i < 1500; i++) begin
            q  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            t0 = 16'($urandom); t1 = 16'($urandom); ta = 16'($urandom);
            step($urandom_range(0, 1) == 1, t0, rnd512(),
                 $urandom_range(0, 1) == 1, t1,
                 $urandom_range(0, 1) == 1, ta, {$urandom, $urandom}, $urandom_range(0, 1) == 1, q);
        end
        idle(2, '0);

        // Reset one cycle after a c0 input discards it
        step(1, 16'h3005, rnd512(), 1, 16'h4001, 0, 16'h0, 64'h0, 0, '0);
        do_reset(2);
        idle(4, '0);

        // Drive drop_cnt to 16'hFFFE, then saturate with triple drops
        for (int i = 0; i < 21844; i++)
            step(1, 16'hF000, '0, 1, 16'hA000, 1, 16'hC000, 64'h0, 0, '0);
        step(1, 16'hF001, '0, 0, 16'h0, 0, 16'h0, 64'h0, 0, '0);
        step(0, 16'h0, '0, 1, 16'hF002, 0, 16'h0, 64'h0, 0, '0);
        for (int i = 0; i < 4; i++)
            step(1, 16'hF000, '0, 1, 16'hB000, 1, 16'hD000, 64'h0, 0, '0);
        idle(3, '0);

        chk("queue_drain", 512'(q0.size() + q1.size() + qm.size()), 512'h0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vai_rx_demux.md
VAI_RX_DEMUX -- requirements
Module: vai_rx_demux

Interface
REQ-001 NUM_SUB_AFUS, default 9, number of downstream sub-AFU ports; legal range 1..15.
REQ-002 TAG_LSB, default 12, lowest bit of the 4-bit AFU-index field in c0/c1 response mdata[15:0] and MMIO address[15:0].
REQ-003 pClk  input  1  sole clock; all logic rising-edge.
REQ-004 SoftReset  input  1  asynchronous, active-high reset.
REQ-005 up_c0_valid  input  1  upstream read response valid.
REQ-006 up_c0_mdata  input  16  read response tag.
REQ-007 up_c0_data  input  512  read response data.
REQ-008 up_c1_valid  input  1  upstream write response valid.
REQ-009 up_c1_mdata  input  16  write response tag.
REQ-010 up_mmio_valid  input  1  upstream MMIO request valid (read or write).
REQ-011 up_mmio_addr  input  16  MMIO DWord address.
REQ-012 up_mmio_wdata  input  64  MMIO write data; up_mmio_rd input 1: 1=read, 0=write.
REQ-013 afu_quiesce  input  NUM_SUB_AFUS  per-AFU drop enable, driven by the manager during sub-AFU reset.
REQ-014 afu_c0_valid/afu_c1_valid/afu_mmio_valid  output  NUM_SUB_AFUS each  per-AFU one-hot valids.
REQ-015 afu_c0_mdata, afu_c1_mdata  output  16  shared tag buses; afu_c0_data output 512; afu_mmio_addr output 16; afu_mmio_wdata output 64; afu_mmio_rd output 1.
REQ-016 drop_cnt  output  16  saturating count of discarded events.
REQ-017 resp_cnt  output  NUM_SUB_AFUS x 16  per-AFU delivered c0+c1 response count, wrapping.

Function
REQ-018 Pipeline: stage 1 registers all upstream inputs; stage 2 decodes and registers all outputs; latency exactly 2 pClk from input valid to output valid; no backpressure, one event per channel per cycle.
REQ-019 Index for c0/c1 = mdata[TAG_LSB+3:TAG_LSB]; index for MMIO = addr[TAG_LSB+3:TAG_LSB].
REQ-020 Routed event: index < NUM_SUB_AFUS and afu_quiesce[index]=0 at stage 2 -> assert only bit [index] of the matching valid vector for one cycle.
REQ-021 Delivered mdata/addr have the 4-bit index field cleared to 0; all other bits and data pass unchanged.
REQ-022 Index >= NUM_SUB_AFUS -> event dropped, no valid asserted, drop_cnt incremented.
REQ-023 afu_quiesce[index]=1 at stage 2 -> event dropped, drop_cnt incremented.
REQ-024 Simultaneous drops on c0, c1, MMIO in one cycle add 1, 2 or 3 to drop_cnt in that cycle; drop_cnt saturates at 16'hFFFF, never wraps.
REQ-025 resp_cnt[i] increments by the number (0..2) of c0/c1 valids delivered to AFU i that cycle; wraps modulo 2^16.
REQ-026 c0, c1 and MMIO channels are independent; same-cycle events to same or different AFUs all delivered.
REQ-027 Data buses when no valid are don't-care but hold the last registered value (no X).
REQ-028 Quiesce is sampled at stage 2, not stage 1; toggling quiesce one cycle after input affects that event.

Reset
REQ-029 SoftReset asserted -> all valid outputs 0, drop_cnt 0, all resp_cnt 0, pipeline valids 0, immediately and asynchronously.
REQ-030 Events in flight at reset assertion are discarded and not counted.
REQ-031 Data/tag registers need no reset.
REQ-032 First input accepted on the first pClk edge after SoftReset deasserts; its output appears 2 cycles later.

Verification
REQ-033 c0 valid, mdata=16'h3005, data=512'hA5.. -> 2 cycles later afu_c0_valid=9'h008, afu_c0_mdata=16'h0005, data unchanged, resp_cnt[3]=1.
REQ-034 MMIO read addr=16'h8010 -> afu_mmio_valid=9'h100, afu_mmio_addr=16'h0010, afu_mmio_rd=1; addr=16'h9010 -> no valid, drop_cnt=1.
REQ-035 Same cycle c0 mdata=16'h1001, c1 mdata=16'h1002 -> afu_c0_valid and afu_c1_valid both 9'h002; resp_cnt[1]+=2.
REQ-036 afu_quiesce=9'h004, c1 mdata=16'h2000 -> no valid, drop_cnt+1; clear quiesce -> next identical event delivered to bit 2.
REQ-037 Preload drop_cnt to 16'hFFFE, three simultaneous invalid-index events -> drop_cnt=16'hFFFF and stays.
REQ-038 Assert SoftReset one cycle after c0 input -> no output valid ever for that event, all counters 0.
